// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package imem_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  // Fetch sequencer states: fetching, draining before a fault, faulted.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // One buffered fetch result: the returned word and the PC it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // A PC is fetchable when it is word aligned and the whole word lies in memory.
  function automatic logic pc_is_legal(input logic [ADDR_W-1:0] pc,
                                       input logic [ADDR_W-1:0] last_pc);
    return (pc[1:0] == 2'b00) && (pc <= last_pc);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of memory, redirect, decode handshake and fault signals around the
// fetch controller. The controller uses the master view, its surroundings
// (memory, decode, branch unit) use the slave view.
interface imem_fetch_ctrl_if;
  import imem_pkg::*;

  // instruction memory side
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;

  // control-flow redirect
  logic               redir_valid;
  logic [ADDR_W-1:0]  redir_pc;

  // decode handshake
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  // fetch fault report
  logic               fault;
  logic [ADDR_W-1:0]  fault_pc;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redir_valid,
    input  redir_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output fault,
    output fault_pc
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redir_valid,
    output redir_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  fault,
    input  fault_pc
  );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry registered FIFO holding fetched words until decode takes them.
// Flush discards everything; push and pop in the same cycle both happen.
module fetch_skid_fifo
  import imem_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  localparam int DEPTH = 2;

  fetch_entry_t entry_reg [DEPTH];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic         do_pop;

  // Popping an empty FIFO is ignored so the pointers can never skew.
  assign do_pop = pop && (count_reg != 2'd0);

  // Pointer and occupancy bookkeeping; flush empties without touching storage.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, push} - {1'b0, do_pop};
    end
  end

  // Entry storage; cleared on reset so the head reads zero until first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else if (push && !flush) begin
      entry_reg[wr_ptr_reg] <= push_entry;
    end
  end

  // The fetch issue rule keeps a slot free for every word in flight.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      push_into_full: assert (!(push && (count_reg == 2'd2)));
    end
  end

  assign count = count_reg;
  assign head  = entry_reg[rd_ptr_reg];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, drives the synchronous
// instruction memory, tracks the one outstanding read, buffers returned words
// for decode and stops cleanly on an unfetchable PC.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       MEM_SIZE = 1024,
  parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
  input  logic               clk,
  input  logic               rst,
  imem_fetch_ctrl_if.master  bus
);

  // Highest byte address at which a full word can still be fetched.
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_SIZE - 32'd4);

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] fetch_pc_reg;
  logic              inflight_reg;
  logic [ADDR_W-1:0] inflight_pc_reg;
  logic              fault_reg;
  logic [ADDR_W-1:0] fault_pc_reg;

  logic [1:0]        fifo_count;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;
  logic              pc_ok;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occupancy_next;

  assign pc_ok = pc_is_legal(fetch_pc_reg, LAST_PC);
  assign pop   = bus.out_valid && bus.out_ready;

  // Slots committed after this cycle: stored words plus the word returning
  // now, minus the one decode takes. A new request needs one slot spare.
  assign occupancy_next = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};

  assign issue = (state_reg == RUN) && pc_ok && (occupancy_next <= 3'd1)
                 && !bus.redir_valid;

  // The memory answers the previous cycle's request; a redirect kills it.
  assign push       = inflight_reg && !bus.redir_valid;
  assign push_entry = '{instr: bus.imem_instr, pc: inflight_pc_reg};

  fetch_skid_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redir_valid),
    .count      (fifo_count),
    .head       (fifo_head)
  );

  // Fetch sequencer: redirect beats everything except reset, then the
  // RUN -> DRAIN -> FAULT progression, otherwise normal sequential issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      fault_reg       <= 1'b0;
      fault_pc_reg    <= '0;
    end else if (bus.redir_valid) begin
      state_reg    <= RUN;
      fetch_pc_reg <= bus.redir_pc;
      inflight_reg <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      inflight_reg <= issue;
      case (state_reg)
        RUN: begin
          if (!pc_ok) begin
            state_reg <= DRAIN;
          end else if (issue) begin
            inflight_pc_reg <= fetch_pc_reg;
            fetch_pc_reg    <= fetch_pc_reg + PC_STEP;
          end
        end
        DRAIN: begin
          // Report the fault only once every good word has reached decode.
          if ((fifo_count == 2'd0) && !inflight_reg && !pop) begin
            state_reg    <= FAULT;
            fault_reg    <= 1'b1;
            fault_pc_reg <= fetch_pc_reg;
          end
        end
        FAULT: begin
          state_reg <= FAULT;
        end
        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

  assign bus.imem_addr = fetch_pc_reg;
  assign bus.out_valid = (fifo_count != 2'd0);
  assign bus.out_instr = fifo_head.instr;
  assign bus.out_pc    = fifo_head.pc;
  assign bus.fault     = fault_reg;
  assign bus.fault_pc  = fault_pc_reg;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus a random
// run scored against an expected-PC-stream model of the fetch behaviour.
module tb_imem_fetch_ctrl;
  import imem_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MEM_SIZE = 1024;
  localparam int          NWORDS   = MEM_SIZE / 4;
  localparam logic [31:0] LAST_PC  = 32'(MEM_SIZE - 4);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] mem_words [NWORDS];
  int checks   = 0;
  int failures = 0;

  imem_fetch_ctrl_if bus ();

  imem_fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .MEM_SIZE (MEM_SIZE),
    .PC_STEP  (32'd4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data for the address seen at a posedge appears after it.
  always @(posedge clk) bus.imem_instr <= mem_words[bus.imem_addr[9:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench inside cycle 0 (first cycle after reset is released).
  task automatic do_reset(input logic ready);
    rst = 1'b1;
    bus.redir_valid = 1'b0;
    bus.redir_pc = 32'h0;
    bus.out_ready = ready;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redir_valid = 1'b1;
    bus.redir_pc = target;
    step();
    bus.redir_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0b exp=0", bus.fault); end
    checks++; if (bus.fault_pc !== 32'h0) begin failures++; $display("FAIL reset_fault_pc got=%h exp=0", bus.fault_pc); end
    checks++; if (bus.out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", bus.out_instr); end
    checks++; if (bus.out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", bus.out_pc); end
    checks++; if (bus.imem_addr !== RESET_PC) begin failures++; $display("FAIL reset_imem_addr got=%h exp=%h", bus.imem_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_cycle1_valid got=%0b exp=0", bus.out_valid); end
    for (int k = 0; k < 4; k++) begin
      step();
      exp_pc = RESET_PC + 32'(4 * k);
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%0b exp=1", k, bus.out_valid); end
      checks++; if (bus.out_pc !== exp_pc) begin failures++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, bus.out_pc, exp_pc); end
      checks++; if (bus.out_instr !== mem_words[exp_pc[9:2]]) begin failures++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, bus.out_instr, mem_words[exp_pc[9:2]]); end
      $display("txn stream pc=%h instr=%h", bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    step();
    step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== mem_words[0]) begin
        failures++; $display("FAIL bp_hold k=%0d got valid=%0b pc=%h instr=%h exp valid=1 pc=0 instr=%h", k, bus.out_valid, bus.out_pc, bus.out_instr, mem_words[0]);
      end
      checks++; if (bus.imem_addr !== 32'h8) begin failures++; $display("FAIL bp_addr k=%0d got=%h exp=00000008", k, bus.imem_addr); end
      if (k == 4) bus.out_ready = 1'b1;
      if (k == 4) $display("txn bp pc=%h instr=%h", bus.out_pc, bus.out_instr);
      step();
    end
    for (int k = 1; k < 4; k++) begin
      exp_pc = 32'(4 * k);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_instr !== mem_words[exp_pc[9:2]]) begin
        failures++; $display("FAIL bp_release k=%0d got valid=%0b pc=%h instr=%h exp pc=%h instr=%h", k, bus.out_valid, bus.out_pc, bus.out_instr, exp_pc, mem_words[exp_pc[9:2]]);
      end
      $display("txn bp pc=%h instr=%h", bus.out_pc, bus.out_instr);
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    step();
    step();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL redir_pre_valid got=%0b exp=1", bus.out_valid); end
    redirect(32'h40);
    checks++; if (bus.imem_addr !== 32'h40) begin failures++; $display("FAIL redir_addr got=%h exp=00000040", bus.imem_addr); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL redir_n1_valid got=%0b exp=0", bus.out_valid); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL redir_n2_valid got=%0b exp=0", bus.out_valid); end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_instr !== mem_words[16]) begin
      failures++; $display("FAIL redir_first got valid=%0b pc=%h instr=%h exp pc=00000040 instr=%h", bus.out_valid, bus.out_pc, bus.out_instr, mem_words[16]);
    end
    $display("txn redir pc=%h instr=%h", bus.out_pc, bus.out_instr);
  endtask

  task automatic test_fault_redirect();
    do_reset(1'b1);
    step();
    step();
    step();
    redirect(32'h3FE);
    checks++; if (bus.imem_addr !== 32'h3FE || bus.fault !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL bad_n1 got addr=%h fault=%0b valid=%0b exp addr=000003fe fault=0 valid=0", bus.imem_addr, bus.fault, bus.out_valid);
    end
    step();
    checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL bad_n2_fault got=%0b exp=0", bus.fault); end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h3FE || bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h3FE) begin
        failures++; $display("FAIL bad_fault k=%0d got fault=%0b fault_pc=%h valid=%0b addr=%h exp 1 000003fe 0 000003fe", k, bus.fault, bus.fault_pc, bus.out_valid, bus.imem_addr);
      end
      step();
    end
    redirect(32'h10);
    checks++; if (bus.fault !== 1'b0 || bus.imem_addr !== 32'h10) begin
      failures++; $display("FAIL recover_n1 got fault=%0b addr=%h exp fault=0 addr=00000010", bus.fault, bus.imem_addr);
    end
    step();
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h10 || bus.out_instr !== mem_words[4]) begin
      failures++; $display("FAIL recover_first got valid=%0b pc=%h instr=%h exp pc=00000010 instr=%h", bus.out_valid, bus.out_pc, bus.out_instr, mem_words[4]);
    end
  endtask

  task automatic test_end_of_mem();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    redirect(32'h3F0);
    exp_pc = 32'h3F0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (bus.fault === 1'b1) break;
      if (bus.out_valid === 1'b1) begin
        checks++; if (bus.out_pc !== exp_pc || bus.out_instr !== mem_words[exp_pc[9:2]]) begin
          failures++; $display("FAIL end_stream got pc=%h instr=%h exp pc=%h instr=%h", bus.out_pc, bus.out_instr, exp_pc, mem_words[exp_pc[9:2]]);
        end
        $display("txn end pc=%h instr=%h", bus.out_pc, bus.out_instr);
        exp_pc = exp_pc + 32'd4;
      end
      step();
    end
    checks++; if (exp_pc !== 32'h400) begin failures++; $display("FAIL end_delivered got next_pc=%h exp=00000400", exp_pc); end
    checks++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h400 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL end_fault got fault=%0b fault_pc=%h valid=%0b exp 1 00000400 0", bus.fault, bus.fault_pc, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    step();
    step();
    step();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%0b exp=1", bus.out_valid); end
    rst = 1'b1;
    bus.redir_valid = 1'b1;
    bus.redir_pc = 32'h80;
    step();
    rst = 1'b0;
    bus.redir_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.fault !== 1'b0 || bus.imem_addr !== RESET_PC) begin
      failures++; $display("FAIL rstmid got valid=%0b fault=%0b addr=%h exp 0 0 %h", bus.out_valid, bus.fault, bus.imem_addr, RESET_PC);
    end
    step();
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== RESET_PC) begin
      failures++; $display("FAIL rstmid_restart got valid=%0b pc=%h exp 1 %h", bus.out_valid, bus.out_pc, RESET_PC);
    end
  endtask

  // Model: after reset or a redirect to P, decode must see P, P+4, ... in
  // order with the matching memory words, until the first unfetchable PC,
  // which is then reported as fault_pc with nothing valid on the output.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] target;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic        prev_hold;
    logic        do_redir;
    logic        exp_legal;
    int          delivered;
    int          sel;
    do_reset(1'b0);
    exp_pc = RESET_PC;
    prev_hold = 1'b0;
    prev_pc = 32'h0;
    prev_instr = 32'h0;
    delivered = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      exp_legal = (exp_pc[1:0] == 2'b00) && (exp_pc <= LAST_PC);
      if (prev_hold) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== prev_pc || bus.out_instr !== prev_instr) begin
          failures++; $display("FAIL rnd_hold cyc=%0d got valid=%0b pc=%h instr=%h exp 1 %h %h", cyc, bus.out_valid, bus.out_pc, bus.out_instr, prev_pc, prev_instr);
        end
      end
      if (bus.fault === 1'b1) begin
        checks++; if (exp_legal || bus.fault_pc !== exp_pc || bus.out_valid !== 1'b0) begin
          failures++; $display("FAIL rnd_fault cyc=%0d got fault_pc=%h valid=%0b exp fault_pc=%h valid=0 (legal=%0b)", cyc, bus.fault_pc, bus.out_valid, exp_pc, exp_legal);
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      do_redir = ($urandom_range(0, 39) == 0) || ((bus.fault === 1'b1) && ($urandom_range(0, 7) == 0));
      sel = $urandom_range(0, 9);
      case (sel)
        0:       target = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
        1:       target = 32'h400 + 32'($urandom_range(0, 64) * 4);
        2:       target = 32'h3E0 + 32'($urandom_range(0, 7) * 4);
        default: target = 32'($urandom_range(0, 255) * 4);
      endcase
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++; if (!exp_legal || bus.out_pc !== exp_pc || bus.out_instr !== mem_words[exp_pc[9:2]]) begin
          failures++; $display("FAIL rnd_txn cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h", cyc, bus.out_pc, bus.out_instr, exp_pc, mem_words[exp_pc[9:2]]);
        end
        $display("txn rnd pc=%h instr=%h", bus.out_pc, bus.out_instr);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      prev_hold = (bus.out_valid === 1'b1) && !bus.out_ready && !do_redir;
      prev_pc = bus.out_pc;
      prev_instr = bus.out_instr;
      if (do_redir) exp_pc = target;
      bus.redir_valid = do_redir;
      bus.redir_pc = target;
      step();
    end
    bus.redir_valid = 1'b0;
    checks++; if (delivered < 300) begin failures++; $display("FAIL rnd_throughput got=%0d exp>=300", delivered); end
  endtask

  initial begin
    bus.redir_valid = 1'b0;
    bus.redir_pc = 32'h0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NWORDS; i++) mem_words[i] = $urandom;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault_redirect();
    test_end_of_mem();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1);
  end

endmodule
